// File: rtl/ext_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_bridge
// Purpose  : Byte-serial external memory bridge. Takes one CPU read/write
//            request at a time and moves it across a shared bidirectional pad
//            bus as BUS_W-wide beats: NA address beats (LS beat first), then
//            ND data beats. Every beat uses a 4-phase handshake (hs_out/hs_in).
//            hs_in is synchronised through two flops before it is used.
// Option   : `define MEMBRIDGE_ADDR_CACHE_EN enables an upper-address cache.
//            After a full address transfer it remembers
//            req_addr[ADDR_W-1:BUS_W]. A later request whose upper bits match
//            a valid entry sends only address beat 0. addr_inval clears the
//            entry. When the macro is undefined, no cache logic is built and
//            addr_inval is ignored.
// Ports    : clk, rst_n (async, active-low)
//            req_rd/req_wr/req_addr/req_wdata  request (held until req_done)
//            req_done/req_rdata                completion pulse, read data
//            addr_inval                        cache invalidate pulse
//            bus_in/bus_out/bus_oe             pad bus
//            bus_phase                         00 idle, 01 first addr beat,
//                                              11 later addr beat, 10 data
//            bus_rd/bus_wr                     transaction type
//            hs_out/hs_in                      strobe / async acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int BUS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_done,
    output logic [DATA_W-1:0] req_rdata,
    input  logic              addr_inval,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [BUS_W-1:0]  bus_out,
    output logic [BUS_W-1:0]  bus_oe,
    output logic [1:0]        bus_phase,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              hs_out,
    input  logic              hs_in
);

    localparam int c_NA   = ADDR_W / BUS_W;
    localparam int c_ND   = DATA_W / BUS_W;
    localparam int c_MAXB = (c_NA > c_ND) ? c_NA : c_ND;
    localparam int c_IW   = (c_MAXB > 1) ? $clog2(c_MAXB) : 1;

    localparam logic [c_IW-1:0] c_LAST_A = c_IW'(c_NA - 1);
    localparam logic [c_IW-1:0] c_LAST_D = c_IW'(c_ND - 1);

    localparam logic [1:0] c_S_IDLE = 2'b00;
    localparam logic [1:0] c_S_ADDR = 2'b01;
    localparam logic [1:0] c_S_DATA = 2'b10;

    localparam logic [1:0] c_PH_IDLE   = 2'b00;
    localparam logic [1:0] c_PH_ADDR0  = 2'b01;
    localparam logic [1:0] c_PH_ADDRN  = 2'b11;
    localparam logic [1:0] c_PH_DATA   = 2'b10;

    logic              r_hs_meta;
    logic              r_hs_s;
    logic [1:0]        r_state;
    logic [c_IW-1:0]   r_beat;
    logic              r_hs_out;
    logic              r_done;
    logic              r_rd;
    logic              r_wr;
    logic              r_skip;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_shadow;

    logic              w_accept;
    logic              w_raise;
    logic              w_beat_done;
    logic              w_addr_last;
    logic              w_data_last;
    logic              w_capture;
    logic              w_store;
    logic              w_hit;
    logic [DATA_W-1:0] w_shadow_next;

    // Two-flop synchroniser; r_hs_s is the only consumer-visible ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_meta <= 1'b0;
            r_hs_s    <= 1'b0;
        end else begin
            r_hs_meta <= hs_in;
            r_hs_s    <= r_hs_meta;
        end
    end

    // A stale ack (hs_s still high from the previous beat) blocks acceptance
    // so the first beat of the new request never sees an old acknowledge.
    assign w_accept    = (r_state == c_S_IDLE) && (req_rd || req_wr) && !r_done && !r_hs_s;
    assign w_raise     = (r_state != c_S_IDLE) && !r_hs_out && !r_hs_s;
    assign w_beat_done = (r_state != c_S_IDLE) && r_hs_out && r_hs_s;
    // A cache hit ends the address phase after beat 0.
    assign w_addr_last = (r_beat == c_LAST_A) || r_skip;
    assign w_data_last = (r_beat == c_LAST_D);
    assign w_capture   = w_beat_done && (r_state == c_S_DATA) && r_rd;
    assign w_store     = w_beat_done && (r_state == c_S_ADDR) && (r_beat == c_LAST_A) && !r_skip;

    // Bus drive is a pure function of state/beat, so it is stable for the
    // whole beat including the setup cycle before hs_out rises.
    always_comb begin
        bus_out   = '0;
        bus_oe    = '0;
        bus_phase = c_PH_IDLE;
        case (r_state)
            c_S_ADDR: begin
                bus_out   = req_addr[int'(r_beat)*BUS_W +: BUS_W];
                bus_oe    = '1;
                bus_phase = (r_beat == '0) ? c_PH_ADDR0 : c_PH_ADDRN;
            end
            c_S_DATA: begin
                bus_phase = c_PH_DATA;
                if (r_wr) begin
                    bus_out = req_wdata[int'(r_beat)*BUS_W +: BUS_W];
                    bus_oe  = '1;
                end
            end
            default: begin
                bus_out   = '0;
                bus_oe    = '0;
                bus_phase = c_PH_IDLE;
            end
        endcase
    end

    // Shadow with the current capture merged in, so the last beat's byte is
    // already present when req_rdata is loaded on the same edge.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_capture) begin
            w_shadow_next[int'(r_beat)*BUS_W +: BUS_W] = bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= w_shadow_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_beat   <= '0;
            r_hs_out <= 1'b0;
            r_done   <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_skip   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_S_ADDR;
                        r_beat  <= '0;
                        r_wr    <= req_wr;
                        r_rd    <= !req_wr;
                        r_skip  <= w_hit;
                    end
                end
                c_S_ADDR: begin
                    if (w_raise) begin
                        r_hs_out <= 1'b1;
                    end else if (w_beat_done) begin
                        r_hs_out <= 1'b0;
                        if (w_addr_last) begin
                            r_state <= c_S_DATA;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + c_IW'(1);
                        end
                    end
                end
                c_S_DATA: begin
                    if (w_raise) begin
                        r_hs_out <= 1'b1;
                    end else if (w_beat_done) begin
                        r_hs_out <= 1'b0;
                        if (w_data_last) begin
                            r_state <= c_S_IDLE;
                            r_beat  <= '0;
                            r_done  <= 1'b1;
                            r_rd    <= 1'b0;
                            r_wr    <= 1'b0;
                            r_skip  <= 1'b0;
                            if (r_rd) begin
                                r_rdata <= w_shadow_next;
                            end
                        end else begin
                            r_beat <= r_beat + c_IW'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= c_S_IDLE;
                    r_hs_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEMBRIDGE_ADDR_CACHE_EN
    generate
        if (c_NA > 1) begin : g_addr_cache
            logic [ADDR_W-BUS_W-1:0] r_tag;
            logic                    r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag   <= '0;
                    r_valid <= 1'b0;
                end else begin
                    if (w_store) begin
                        r_tag <= req_addr[ADDR_W-1:BUS_W];
                    end
                    // Invalidate wins over a store in the same cycle.
                    if (addr_inval) begin
                        r_valid <= 1'b0;
                    end else if (w_store) begin
                        r_valid <= 1'b1;
                    end
                end
            end

            assign w_hit = r_valid && !addr_inval && (req_addr[ADDR_W-1:BUS_W] == r_tag);
        end else begin : g_no_cache
            logic w_unused_cache;
            assign w_hit          = 1'b0;
            assign w_unused_cache = addr_inval ^ w_store;
        end
    endgenerate
`else
    logic w_unused_cache;
    assign w_hit          = 1'b0;
    assign w_unused_cache = addr_inval ^ w_store;
`endif

    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign bus_rd    = r_rd;
    assign bus_wr    = r_wr;
    assign hs_out    = r_hs_out;

endmodule
`default_nettype wire
